// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO with set/clear and hardware blink.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE   = 3'd2;
    localparam logic [2:0] ADDR_STATUS     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET     = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;

    localparam int unsigned STATUS_PHASE_BIT = 31;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running blink prescaler: phase toggles every PRESCALE cycles, held at 1 when PRESCALE is 0.
module blink_prescaler #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] prescale_i,
    input  logic             load_i,
    output logic             phase_o,
    output logic             phase_next_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // A PRESCALE write restarts the period and beats a coincident terminal count.
        if (load_i || (prescale_i == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == prescale_i - CNT_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o      = phase_q;
    assign phase_next_o = phase_d;

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED PIO: data register, atomic set/clear, per-bit blink mask and status readback.
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int unsigned          WIDTH            = 5,
    parameter int unsigned          CNT_W            = 24,
    parameter logic [WIDTH-1:0]     RESET_VALUE      = '0,
    parameter logic [CNT_W-1:0]     DEFAULT_PRESCALE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] blink_mask_q, blink_mask_d;
    logic [CNT_W-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             prescale_load;
    logic             phase_q, phase_d;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_comb begin
        data_out_d    = data_out_q;
        blink_mask_d  = blink_mask_q;
        prescale_d    = prescale_q;
        prescale_load = 1'b0;
        if (chipselect && !write_n) begin
            case (address)
                ADDR_DATA:       data_out_d   = writedata[WIDTH-1:0];
                ADDR_BLINK_MASK: blink_mask_d = writedata[WIDTH-1:0];
                ADDR_PRESCALE: begin
                    prescale_d    = writedata[CNT_W-1:0];
                    prescale_load = 1'b1;
                end
                ADDR_OUTSET:     data_out_d   = data_out_q | writedata[WIDTH-1:0];
                ADDR_OUTCLEAR:   data_out_d   = data_out_q & ~writedata[WIDTH-1:0];
                default: ;
            endcase
        end
        // Use next-state values so writes and phase toggles land on out_port in the same edge.
        out_d = data_out_d & ~(blink_mask_d & {WIDTH{~phase_d}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= RESET_VALUE;
            blink_mask_q <= '0;
            prescale_q   <= DEFAULT_PRESCALE;
            out_q        <= RESET_VALUE;
        end else begin
            data_out_q   <= data_out_d;
            blink_mask_q <= blink_mask_d;
            prescale_q   <= prescale_d;
            out_q        <= out_d;
        end
    end

    blink_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk          (clk),
        .reset        (reset),
        .prescale_i   (prescale_d),
        .load_i       (prescale_load),
        .phase_o      (phase_q),
        .phase_next_o (phase_d)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata[WIDTH-1:0] = data_out_q;
            ADDR_BLINK_MASK: readdata[WIDTH-1:0] = blink_mask_q;
            ADDR_PRESCALE:   readdata[CNT_W-1:0] = prescale_q;
            ADDR_STATUS: begin
                readdata[WIDTH-1:0]        = out_q;
                readdata[STATUS_PHASE_BIT] = phase_q;
            end
            default: ;
        endcase
    end

    assign out_port = out_q;

endmodule

// File: doc/led_pio_blink.md
Name: led_pio_blink

Overview:
- Parametrised successor to the fixed 5-bit LED output port: an Avalon-MM slave driving WIDTH LED outputs.
- Adds atomic bit set/clear registers, per-bit hardware blink with a programmable prescaler, and status readback.
- Sits on the Nios II data master interconnect in place of the plain LED PIO; out_port goes straight to the board LED pins.

Parameters:
- WIDTH, 5, number of LED outputs (1..31).
- CNT_W, 24, prescaler counter and PRESCALE register width (1..32).
- RESET_VALUE, 0, value of the DATA register after reset (WIDTH bits).
- DEFAULT_PRESCALE, 0, value of the PRESCALE register after reset (0 = blink off).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset. All state is sampled on the rising edge of clk.
- Write strobe: a write occurs on a rising edge where chipselect=1 and write_n=0. Writedata bits above the register width are ignored.
- Register map, addr 0, DATA (rw): data_out <= writedata[WIDTH-1:0].
- Register map, addr 1, BLINK_MASK (rw): bit i=1 makes LED i blink.
- Register map, addr 2, PRESCALE (rw, CNT_W bits): a write also forces cnt<=0 and phase<=1 on the same edge.
- Register map, addr 3, STATUS (ro): [WIDTH-1:0] = out_port; bit31 = phase; other bits 0.
- Register map, addr 4, OUTSET (wo): data_out <= data_out | writedata[WIDTH-1:0]; reads 0.
- Register map, addr 5, OUTCLEAR (wo): data_out <= data_out & ~writedata[WIDTH-1:0]; reads 0.
- Register map, addr 6-7: reserved; reads 0; writes ignored.
- Read: readdata = zero-extended register selected by address, independent of chipselect. DATA reads back data_out, not out_port.
- Prescaler, PRESCALE=0: cnt held at 0 and phase held at 1; no blinking.
- Prescaler, PRESCALE=P>0: cnt increments every cycle. When cnt==P-1, cnt wraps to 0 and phase toggles. Half-period is P cycles; full blink period is 2P cycles.
- Prescaler, PRESCALE written smaller than current cnt: there is no stale-count hazard, because the write resets cnt to 0.
- Prescaler, PRESCALE write on the same edge as terminal count: the write wins (cnt<=0, phase<=1, no toggle).
- Output: out_port <= data_out_next & ~(blink_mask_next & {WIDTH{~phase_next}}), registered. "_next" means the value being loaded on the same edge.
- Latency: a DATA/OUTSET/OUTCLEAR/BLINK_MASK write on edge N is visible on out_port after edge N; readdata reflects it after edge N.
- Blink lag: a phase toggle on edge N appears on out_port after edge N.
- Blinked bits go off when phase=0 and show data_out when phase=1. A blinked bit with data_out=0 stays off.
- Reset values: data_out=RESET_VALUE, blink_mask=0, prescale=DEFAULT_PRESCALE, cnt=0, phase=1, out_port=RESET_VALUE.
- Reset mid-operation: reset overrides any simultaneous write. readdata reflects reset values from the next cycle.
- Transaction ordering: only one Avalon transaction per cycle, so no write-write conflicts exist. Set/clear are atomic read-modify-write inside the block.

Decomposition:
- Shared package led_pio_pkg: address constants ADDR_DATA=0, ADDR_BLINK_MASK=1, ADDR_PRESCALE=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5; STATUS_PHASE_BIT=31.
- Sub-module blink_prescaler (params CNT_W).
  - Inputs: clk, reset, prescale, load (PRESCALE write strobe).
  - Output: phase.
  - Contains cnt and the phase flop.
- Top level holds the register file, read mux and output register.

Test Plan:
- Reset, WIDTH=5, RESET_VALUE=5'h15 -> out_port=5'h15; read addr0=0x15, addr1=0, addr2=DEFAULT_PRESCALE, addr3=0x8000_0015.
- Write DATA=0xFFFF_FFE3 -> data_out=5'h03; out_port=5'h03 one edge later. Then OUTSET 0x10 -> 5'h13; OUTCLEAR 0x01 -> 5'h12; read addr4 and addr5 -> 0.
- DATA=5'h1F, BLINK_MASK=5'h01, PRESCALE=4 -> bit0 on 4 cycles, off 4 cycles, repeating; bits 4:1 steady 1; STATUS bit31 tracks phase.
- PRESCALE=3 running, rewrite PRESCALE=3 on the terminal-count edge -> no toggle; phase=1; next toggle exactly 3 cycles later.
- PRESCALE=0 with BLINK_MASK=5'h1F, DATA=5'h0A -> out_port constant 5'h0A for 100 cycles.
- Assert reset for 1 cycle during a DATA write while blinking -> all reset values restored; the write is discarded; phase=1.
